// File: rtl/tick_scheduler.sv
// tick_scheduler: run/pause/stop controller with a programmable prescaler.
// Counts speed_clock cycles and emits a one-cycle tick every `period`
// cycles plus a low_clock square wave that toggles on each tick. A new
// period arrives through a valid/ready handshake. In IDLE it is applied
// at once. While running it waits until the next terminal count, so the
// period never changes in the middle of a count.
// Optional build macro: ONESHOT_EN adds the one_shot input. A start with
// one_shot=1 produces exactly one tick and then returns to IDLE.
module tick_scheduler #(
   parameter int CNT_W          = 27,
   parameter int DEFAULT_PERIOD = 25000000,
   parameter int MIN_PERIOD     = 2
) (
   input  logic             speed_clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
`ifdef ONESHOT_EN
   input  logic             one_shot,
`endif
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_period,
   output logic             cfg_ready,
   output logic             tick,
   output logic             low_clock,
   output logic             busy,
   output logic [1:0]       state,
   output logic [7:0]       tick_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cont_reg, cont_next;
   logic [CNT_W-1:0] period_reg, period_next;
   logic [CNT_W-1:0] pend_val_reg, pend_val_next;
   logic             cfg_ready_reg, cfg_ready_next;   // low means a config is pending
   logic             tick_reg, tick_next;
   logic             low_reg, low_next;
   logic             busy_reg, busy_next;
   logic [7:0]       tick_cnt_reg, tick_cnt_next;

   logic             accept;
   logic [CNT_W-1:0] acc_val;
   logic             terminal;
   logic             go_idle;

   assign accept   = cfg_valid && cfg_ready_reg;
   assign acc_val  = (cfg_period < MIN_P) ? MIN_P : cfg_period;
   // period never drops below MIN_PERIOD, so period-1 cannot underflow
   assign terminal = (cont_reg == (period_reg - ONE));

`ifdef ONESHOT_EN
   logic oneshot_reg, oneshot_next;
   // a one-shot run leaves on the edge after its first tick
   assign go_idle = stop || (oneshot_reg && tick_reg);
`else
   assign go_idle = stop;
`endif

   // next-state and next-output logic for the controller and prescaler
   always_comb begin
      state_next     = state_reg;
      cont_next      = cont_reg;
      period_next    = period_reg;
      pend_val_next  = pend_val_reg;
      cfg_ready_next = cfg_ready_reg;
      tick_next      = 1'b0;
      low_next       = low_reg;
      tick_cnt_next  = tick_cnt_reg;
`ifdef ONESHOT_EN
      oneshot_next   = oneshot_reg;
`endif
      case (state_reg)
         ST_IDLE: begin
            cont_next = '0;
            low_next  = 1'b0;
            if (accept) begin
               period_next = acc_val;
            end
            if (start && !stop) begin
               state_next    = ST_RUN;
               tick_cnt_next = 8'd0;
`ifdef ONESHOT_EN
               oneshot_next  = one_shot;
`endif
            end
         end
         ST_RUN, ST_PAUSE: begin
            if (go_idle) begin
               // leaving: a config offered now or already pending takes effect at once
               state_next = ST_IDLE;
               cont_next  = '0;
               low_next   = 1'b0;
               if (accept) begin
                  period_next = acc_val;
               end else if (!cfg_ready_reg) begin
                  period_next    = pend_val_reg;
                  cfg_ready_next = 1'b1;
               end
            end else begin
               if (state_reg == ST_RUN) begin
                  if (terminal) begin
                     cont_next     = '0;
                     tick_next     = 1'b1;
                     low_next      = ~low_reg;
                     tick_cnt_next = tick_cnt_reg + 8'd1;
                     if (!cfg_ready_reg) begin
                        period_next    = pend_val_reg;
                        cfg_ready_next = 1'b1;
                     end
                  end else begin
                     cont_next = cont_reg + ONE;
                  end
               end
               // accept is only possible when nothing is pending, so no clash with the apply above
               if (accept) begin
                  pend_val_next  = acc_val;
                  cfg_ready_next = 1'b0;
               end
               state_next = pause ? ST_PAUSE : ST_RUN;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cont_next  = '0;
            low_next   = 1'b0;
         end
      endcase
      busy_next = (state_next != ST_IDLE);
   end

   // state and output registers, cleared asynchronously by reset
   always_ff @(posedge speed_clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         cont_reg      <= '0;
         period_reg    <= DEF_P;
         pend_val_reg  <= '0;
         cfg_ready_reg <= 1'b1;
         tick_reg      <= 1'b0;
         low_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         tick_cnt_reg  <= 8'd0;
`ifdef ONESHOT_EN
         oneshot_reg   <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         cont_reg      <= cont_next;
         period_reg    <= period_next;
         pend_val_reg  <= pend_val_next;
         cfg_ready_reg <= cfg_ready_next;
         tick_reg      <= tick_next;
         low_reg       <= low_next;
         busy_reg      <= busy_next;
         tick_cnt_reg  <= tick_cnt_next;
`ifdef ONESHOT_EN
         oneshot_reg   <= oneshot_next;
`endif
      end
   end

   assign cfg_ready = cfg_ready_reg;
   assign tick      = tick_reg;
   assign low_clock = low_reg;
   assign busy      = busy_reg;
   assign state     = state_reg;
   assign tick_cnt  = tick_cnt_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed scenarios with hand-computed
// expectations, then randomized stimulus compared every cycle against a
// behavioural model of the scheduler. Build with ONESHOT_EN to also
// cover the one-shot run.
module tb_tick_scheduler;

   logic        speed_clock;
   logic        reset;
   logic        start, stop, pause;
   logic        cfg_valid;
   logic [26:0] cfg_period;
   logic        cfg_ready, tick, low_clock, busy;
   logic [1:0]  state;
   logic [7:0]  tick_cnt;
`ifdef ONESHOT_EN
   logic        one_shot;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   tick_scheduler dut (
      .speed_clock (speed_clock),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
`ifdef ONESHOT_EN
      .one_shot    (one_shot),
`endif
      .cfg_valid   (cfg_valid),
      .cfg_period  (cfg_period),
      .cfg_ready   (cfg_ready),
      .tick        (tick),
      .low_clock   (low_clock),
      .busy        (busy),
      .state       (state),
      .tick_cnt    (tick_cnt)
   );

   initial begin
      speed_clock = 1'b0;
      forever #10 speed_clock = ~speed_clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_state: 0 idle, 1 run, 2 pause. m_elapsed counts active cycles in the current period.
   int m_state, m_elapsed, m_period, m_pend_val, m_cnt;
   bit m_pend, m_tick, m_low, m_os;

   always @(posedge speed_clock or negedge reset) begin : model
      bit acc;
      bit leave;
      int av;
      if (!reset) begin
         m_state = 0; m_elapsed = 0; m_period = 25000000; m_pend_val = 0;
         m_cnt = 0; m_pend = 0; m_tick = 0; m_low = 0; m_os = 0;
      end else begin
         acc = cfg_valid && !m_pend;
         av  = (cfg_period < 2) ? 2 : int'(cfg_period);
         if (m_state == 0) begin
            m_tick = 0; m_elapsed = 0; m_low = 0;
            if (acc) m_period = av;
            if (start && !stop) begin
               m_state = 1;
               m_cnt   = 0;
`ifdef ONESHOT_EN
               m_os    = one_shot;
`endif
            end
         end else begin
            leave = stop;
`ifdef ONESHOT_EN
            if (m_os && m_tick) leave = 1;
`endif
            if (leave) begin
               m_state = 0; m_elapsed = 0; m_low = 0; m_tick = 0;
               if (acc) m_period = av;
               else if (m_pend) begin m_period = m_pend_val; m_pend = 0; end
            end else begin
               m_tick = 0;
               if (m_state == 1) begin
                  m_elapsed = m_elapsed + 1;
                  if (m_elapsed == m_period) begin
                     m_elapsed = 0;
                     m_tick    = 1;
                     m_low     = !m_low;
                     m_cnt     = (m_cnt + 1) % 256;
                     if (m_pend) begin m_period = m_pend_val; m_pend = 0; end
                  end
               end
               if (acc) begin m_pend_val = av; m_pend = 1; end
               m_state = pause ? 2 : 1;
            end
         end
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge speed_clock) begin
      logic [13:0] got, want;
      if (chk_en) begin
         got  = {cfg_ready, tick, low_clock, busy, state, tick_cnt};
         want = {!m_pend, m_tick, m_low, (m_state != 0), m_state[1:0], m_cnt[7:0]};
         chk("cycle_outputs{rdy,tick,low,busy,state,cnt}", {18'd0, got}, {18'd0, want});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge speed_clock);
   endtask

   task automatic cfg_idle(input int p);
      cfg_valid  = 1'b1;
      cfg_period = 27'(p);
      cyc();
      cfg_valid  = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
   endtask

   initial begin : stim
      logic [31:0] mask;
      logic        low_at2;
      bit          force_cfg;
      reset = 1'b0; start = 0; stop = 0; pause = 0; cfg_valid = 0; cfg_period = '0;
`ifdef ONESHOT_EN
      one_shot = 1'b0;
`endif
      cyc(); cyc();
      reset  = 1'b1;
      chk_en = 1;

      // reset defaults
      chk("rst_tick", {31'd0, tick}, 0);
      chk("rst_low", {31'd0, low_clock}, 0);
      chk("rst_ready", {31'd0, cfg_ready}, 1);
      chk("rst_state", {30'd0, state}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_tick_cnt", {24'd0, tick_cnt}, 0);

      // period 5: ticks 5, 10, 15 cycles after entering RUN
      cfg_idle(5);
      go();
      chk("p5_state_run", {30'd0, state}, 1);
      mask = 0;
      for (int i = 1; i <= 15; i++) begin
         cyc();
         mask[i-1] = tick;
         if (i == 5) chk("p5_low_first", {31'd0, low_clock}, 1);
      end
      chk("p5_tick_times", mask, 32'h0000_4210);
      chk("p5_tick_cnt", {24'd0, tick_cnt}, 3);
      chk("p5_low_end", {31'd0, low_clock}, 1);
      halt();
      chk("p5_stop_state", {30'd0, state}, 0);

      // period 0 is clamped to 2
      cfg_idle(0);
      go();
      mask = 0;
      low_at2 = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         mask[i-1] = tick;
         if (i == 2) low_at2 = low_clock;
      end
      chk("clamp_tick_times", mask, 32'h0000_00AA);
      chk("clamp_low_at2", {31'd0, low_at2}, 1);
      chk("clamp_low_at8", {31'd0, low_clock}, 0);
      halt();

      // period 10 with a 7-cycle pause after 4 cycles: first tick at 17
      cfg_idle(10);
      go();
      mask = 0;
      for (int i = 1; i <= 20; i++) begin
         pause = (i >= 5 && i <= 11);
         cyc();
         mask[i-1] = tick;
         if (i == 8) chk("pause_state", {30'd0, state}, 2);
      end
      pause = 1'b0;
      chk("pause_tick_times", mask, 32'h0001_0000);
      halt();

      // period 10, new period 4 offered at cycle 3: applied at tick 10
      go();
      mask = 0;
      for (int i = 1; i <= 18; i++) begin
         cfg_valid  = (i == 3);
         cfg_period = 27'd4;
         cyc();
         mask[i-1] = tick;
         if (i == 3)  chk("pend_ready_c3", {31'd0, cfg_ready}, 0);
         if (i == 9)  chk("pend_ready_c9", {31'd0, cfg_ready}, 0);
         if (i == 10) chk("pend_ready_c10", {31'd0, cfg_ready}, 1);
      end
      cfg_valid = 1'b0;
      chk("pend_tick_times", mask, 32'h0002_2200);
      halt();

      // period 6, stop on the terminal-count edge: no tick
      cfg_idle(6);
      go();
      mask = 0;
      for (int i = 1; i <= 6; i++) begin
         stop = (i == 6);
         cyc();
         mask[i-1] = tick;
      end
      stop = 1'b0;
      chk("stop_tc_no_tick", mask, 0);
      chk("stop_tc_state", {30'd0, state}, 0);
      chk("stop_tc_low", {31'd0, low_clock}, 0);

      // asynchronous reset mid-count
      go();
      for (int i = 1; i <= 8; i++) cyc();
      chk("pre_rst_tick_cnt", {24'd0, tick_cnt}, 1);
      #3 reset = 1'b0;
      #1;
      chk("arst_state", {30'd0, state}, 0);
      chk("arst_tick_cnt", {24'd0, tick_cnt}, 0);
      chk("arst_low", {31'd0, low_clock}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_ready", {31'd0, cfg_ready}, 1);
      #2 reset = 1'b1;
      cyc();

`ifdef ONESHOT_EN
      // one-shot with period 3: single tick, then back to IDLE
      cfg_idle(3);
      one_shot = 1'b1;
      go();
      one_shot = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         if (i == 3) begin
            chk("os_tick", {31'd0, tick}, 1);
            chk("os_tick_cnt3", {24'd0, tick_cnt}, 1);
         end
         if (i == 4) begin
            chk("os_state", {30'd0, state}, 0);
            chk("os_busy", {31'd0, busy}, 0);
            chk("os_tick_cnt4", {24'd0, tick_cnt}, 1);
            chk("os_low", {31'd0, low_clock}, 0);
         end
      end
`endif

      // randomized phase checked against the model every cycle
      force_cfg = 1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            #3 reset = 1'b0;
            #3 reset = 1'b1;
            force_cfg = 1;
         end
         start      = ($urandom_range(0, 9) == 0);
         stop       = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 7) == 0) pause = ~pause;
         cfg_valid  = force_cfg || ($urandom_range(0, 7) == 0);
         cfg_period = 27'($urandom_range(0, 12));
`ifdef ONESHOT_EN
         one_shot   = ($urandom_range(0, 3) == 0);
`endif
         force_cfg  = 0;
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
